// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if -- EX-stage <-> RV32M multiply/divide unit handshake.
//   master (EX stage): drives req_valid, funct3, op_a, op_b, flush;
//                      observes stall, result_valid, result, busy.
//   slave  (muldiv_seq): the mirror image.
interface muldiv_seq_if #(
    parameter int XLEN = 32
) ();
    logic            req_valid;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output req_valid, funct3, op_a, op_b, flush,
        input  stall, result_valid, result, busy
    );

    modport slave (
        input  req_valid, funct3, op_a, op_b, flush,
        output stall, result_valid, result, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq -- sequential RV32M multiplier/divider (32 iterations per op).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_seq_if.slave: req_valid/funct3/op_a/op_b/flush in,
//          stall/result_valid/result/busy out
// Operands are converted to magnitudes on acceptance, iterated unsigned
// (shift-add or restoring divide) and the final value is negated if needed.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg, state_next;
    logic [5:0]      cnt_reg;
    logic [2:0]      f3_reg;
    logic            neg_reg;
    logic [XLEN-1:0] hi_reg, lo_reg, mcand_reg, result_reg;

    // ---------------- acceptance-time decode ----------------
    logic            signed_a, signed_b, a_neg, b_neg, is_div;
    logic            div_zero, div_ovf, fast, accept;
    logic [XLEN-1:0] abs_a, abs_b, fast_result;

    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin signed_a = 1'b1; signed_b = 1'b1; end
            3'b010:                 signed_a = 1'b1;
            default: ;
        endcase
    end

    assign is_div   = bus.funct3[2];
    assign a_neg    = signed_a & bus.op_a[XLEN-1];
    assign b_neg    = signed_b & bus.op_b[XLEN-1];
    assign abs_a    = a_neg ? -bus.op_a : bus.op_a;
    assign abs_b    = b_neg ? -bus.op_b : bus.op_b;
    assign div_zero = is_div && (bus.op_b == '0);
    assign div_ovf  = is_div && !bus.funct3[0]
                      && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.op_b == '1);
    assign fast     = div_zero || div_ovf;
    assign accept   = (state_reg == IDLE) && bus.req_valid && !bus.flush;

    // Divide-by-zero: quotient all ones, remainder = dividend.
    // Overflow: quotient = dividend (0x80000000), remainder 0.
    always_comb begin
        if (div_zero)
            fast_result = bus.funct3[1] ? bus.op_a : '1;
        else
            fast_result = bus.funct3[1] ? '0 : bus.op_a;
    end

    // ---------------- one iteration step ----------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic            div_ge;
    logic [XLEN-1:0] div_diff, hi_step, lo_step;

    assign mul_sum  = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? mcand_reg : '0)};
    assign rem_sh   = {hi_reg, lo_reg[XLEN-1]};
    assign div_ge   = rem_sh >= {1'b0, mcand_reg};
    // When div_ge holds the true difference is below the divisor, so the
    // truncated subtraction is exact.
    assign div_diff = rem_sh[XLEN-1:0] - mcand_reg;

    always_comb begin
        if (f3_reg[2]) begin
            hi_step = div_ge ? div_diff : rem_sh[XLEN-1:0];
            lo_step = {lo_reg[XLEN-2:0], div_ge};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
    end

    // Final value formed from the last step's outputs.
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0]   div_sel, final_result;

    assign prod_fin = neg_reg ? -{hi_step, lo_step} : {hi_step, lo_step};
    assign div_sel  = f3_reg[1] ? hi_step : lo_step;

    always_comb begin
        if (f3_reg[2])
            final_result = neg_reg ? -div_sel : div_sel;
        else if (f3_reg[1:0] == 2'b00)
            final_result = prod_fin[XLEN-1:0];
        else
            final_result = prod_fin[2*XLEN-1:XLEN];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = fast ? DONE : CALC;
            CALC: if (cnt_reg == 6'd31) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            f3_reg     <= '0;
            neg_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            mcand_reg  <= '0;
            result_reg <= '0;
        end else if (accept) begin
            cnt_reg   <= '0;
            f3_reg    <= bus.funct3;
            // Remainder follows the dividend; everything else the XOR.
            neg_reg   <= (is_div && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
            hi_reg    <= '0;
            lo_reg    <= is_div ? abs_a : abs_b;
            mcand_reg <= is_div ? abs_b : abs_a;
            if (fast) result_reg <= fast_result;
        end else if (state_reg == CALC && !bus.flush) begin
            cnt_reg <= cnt_reg + 6'd1;
            hi_reg  <= hi_step;
            lo_reg  <= lo_step;
            if (cnt_reg == 6'd31) result_reg <= final_result;
        end
    end

    // ---------------- outputs ----------------
    logic rv;
    assign rv               = (state_reg == DONE);
    assign bus.result_valid = rv;
    assign bus.result       = result_reg;
    assign bus.busy         = (state_reg != IDLE);
    assign bus.stall        = bus.req_valid & ~rv & ~bus.flush;
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; only 32 is required.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  EX holds an RV32M instruction; stays high until result_valid unless flushed.
REQ-005 funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  XLEN  rs1 value after forwarding.
REQ-007 op_b  input  XLEN  rs2 value after forwarding.
REQ-008 flush  input  1  branch flush of EX; aborts any operation.
REQ-009 stall  output  1  freezes IF/ID/EX while an operation is pending.
REQ-010 result_valid  output  1  one-cycle strobe, result is valid.
REQ-011 result  output  XLEN  product/quotient/remainder selected by funct3.
REQ-012 busy  output  1  state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 IDLE with req_valid=1 and flush=0 at an edge: latch funct3, op_a and op_b; clear the 6-bit counter; go to CALC.
REQ-015 Fast path: for DIV/DIVU/REM/REMU with op_b=0, or DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF, IDLE SHALL go directly to DONE.
REQ-016 CALC SHALL do one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle and increment the counter.
REQ-017 CALC SHALL go to DONE on the edge where the counter reaches 31 (32 CALC cycles).
REQ-018 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-019 Latency: result_valid SHALL be high in the 34th cycle counted from the first cycle req_valid is high (accept, 32 CALC, DONE); on the fast path it SHALL be high in the 2nd cycle.
REQ-020 stall SHALL equal req_valid & ~result_valid & ~flush (combinational).
REQ-021 stall SHALL be low in the DONE cycle so the pipeline advances on that edge.
REQ-022 result SHALL hold its value outside DONE; only result_valid qualifies it.
REQ-023 Signed ops SHALL take absolute values of the signed operands, iterate unsigned, then negate the result when required:
- MULH: both operands signed.
- MULHSU: op_a signed, op_b unsigned.
- Quotient sign: sign(a) XOR sign(b).
- Remainder sign: sign of the dividend.
REQ-024 MUL SHALL return product bits [31:0]; MULH, MULHSU and MULHU SHALL return bits [63:32].
REQ-025 Divide by zero SHALL return quotient 0xFFFFFFFF and remainder op_a.
REQ-026 Signed overflow (0x80000000 / -1) SHALL return quotient 0x80000000 and remainder 0.
REQ-027 flush=1 in any state SHALL force IDLE on the next edge; no result_valid SHALL follow for the aborted operation.
REQ-028 flush and req_valid both high in IDLE SHALL NOT start an operation.
REQ-029 A req_valid held high in the cycle after DONE SHALL be treated as a new instruction (back-to-back ops are legal).
REQ-030 Operand changes on op_a/op_b after acceptance SHALL NOT affect the result.

Reset
REQ-031 rst_n=0 SHALL asynchronously set state IDLE, counter 0, result 0, result_valid 0, busy 0 and all internal registers 0.
REQ-032 Reset asserted mid-CALC SHALL discard the operation.
REQ-033 After rst_n rises, a held req_valid SHALL be accepted on the first clock edge.

Verification
REQ-034 MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB; result_valid high in cycle 34; stall high in cycles 1-33, low in cycle 34.
REQ-035 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-036 DIVU 100/0 -> 0xFFFFFFFF in cycle 2; REMU 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
REQ-037 REM 0xFFFFFFF9/2 -> 0xFFFFFFFF; DIV of the same -> 0xFFFFFFFD; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-038 flush pulsed in CALC cycle 10 -> IDLE next cycle; no result_valid; stall low; a following MUL 3x4 -> 12 with full latency.
REQ-039 rst_n low mid-CALC -> all outputs 0 immediately; back-to-back DIVU then MUL -> two result_valid strobes 34 cycles apart.
